day07_rom_loader: RTL and testbench
===================================

Name: day07_rom_loader

Overview:
- Responder/memory end of the puzzle-ROM read interface consumed by the day-07 solver core.
- Accepts the puzzle text as a byte stream with valid/ready handshaking, stores it in an internal byte RAM, then serves combinational byte reads addressed by the core.
- Holds the core in reset until the input is fully loaded and normalised: CRs stripped, final newline guaranteed.

Parameters:
- N_ADDR_BITS, 16, storage capacity is DEPTH = 2**N_ADDR_BITS bytes; the read address is N_ADDR_BITS+1 bits.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- in_byte  input  8  input text byte
- in_valid  input  1  in_byte valid
- in_last  input  1  qualifies the final byte of the file; meaningful only with in_valid
- in_ready  output  1  loader accepts a byte this cycle
- rom_addr  input  N_ADDR_BITS+1  byte address from the core
- rom_data  output  8  byte at rom_addr, combinational
- rom_valid  output  1  memory loaded and serving
- core_rst  output  1  active-high reset to the solver core
- byte_count  output  N_ADDR_BITS+1  number of bytes stored, including any appended newline
- overflow  output  1  sticky; input exceeded DEPTH
- load_done  output  1  one-cycle pulse on entry to S_RUN

Behaviour:
- States: S_LOAD, S_TERM, S_RUN.
- Reset values: state S_LOAD, byte_count 0, overflow 0, rom_valid 0, core_rst 1, load_done 0. in_ready is 1 in the first cycle after reset.
- Memory contents are not cleared on reset. Reads at or beyond byte_count return 0, so stale data is never visible.
- S_LOAD:
  - in_ready = 1.
  - Transfer occurs when in_valid && in_ready.
  - 0x0D bytes are discarded: no write, no count change.
  - Any other byte is written at mem[byte_count] and byte_count increments, provided byte_count < DEPTH. Otherwise the byte is dropped and overflow is set.
  - A transfer with in_last moves to S_TERM next cycle. This applies even when the last byte is a CR or is dropped.
- S_TERM (one cycle):
  - in_ready = 0.
  - If byte_count > 0, the last stored byte != 0x0A, and byte_count < DEPTH: write 0x0A at mem[byte_count] and increment byte_count.
  - If a newline is needed but memory is full: set overflow, no write.
  - Next state is S_RUN.
- S_RUN:
  - in_ready = 0 and input is ignored.
  - rom_valid = 1 and core_rst = 0, both registered, asserted from the first S_RUN cycle.
  - load_done pulses high for exactly that first cycle.
  - Remains in S_RUN until rst.
- Read port: rom_data = mem[rom_addr] when state == S_RUN and rom_addr < byte_count; otherwise 0x00.
  - Zero-latency combinational read, because the core samples rom_data in the same cycle it drives rom_addr.
  - The returned 0x00 acts as the EOF marker.
  - Addresses >= DEPTH, including the MSB of rom_addr, always return 0.
- byte_count width N_ADDR_BITS+1 holds DEPTH exactly; it never wraps.
- Empty file: a single in_last transfer with a CR, or with byte_count 0, gives byte_count 0, no newline appended, and every rom_data is 0.
- Reset mid-load or mid-run: returns to S_LOAD with byte_count 0 and core_rst 1 immediately in the cycle after reset; the core is held in reset again.
- Simultaneous in_valid and in_last on a CR: CR discarded, transition still taken.

Test Plan:
- Stream ".S.\n^.^\n" (8 bytes, in_last on the final byte) with in_valid held high -> in_ready high for 8 cycles; load_done after S_TERM; byte_count 8. Reads give addr 1 = "S", addr 7 = 0x0A, addr 8 = 0x00.
- Stream "ab\r\ncd" with in_last on 'd' -> CR stripped, newline appended, byte_count 6. Memory reads "ab\ncd\n"; addr 6 = 0x00.
- Insert random in_valid gaps (30% idle) -> contents identical to the back-to-back case; no byte duplicated or lost.
- N_ADDR_BITS = 3, stream 10 non-newline bytes -> first 8 stored; overflow = 1; byte_count 8; no newline appended; rom_valid still asserts.
- Assert rst after 3 bytes, then stream "x\n" -> byte_count 2; addr 2 reads 0x00 (old data hidden); core_rst held 1 until S_RUN.
- Before load completes, drive rom_addr = 0 -> rom_data 0x00, rom_valid 0, core_rst 1. After S_RUN, rom_addr with MSB set -> 0x00.

Source files
------------

// File: rtl/day07_rom_loader.sv
`default_nettype none
// ============================================================================
//  Module   : day07_rom_loader
//  Brief    : Loads the day-07 puzzle text from a valid/ready byte stream
//             into an internal byte RAM, strips CRs, guarantees a final
//             newline, then serves zero-latency reads to the solver core
//             while releasing it from reset.
//  Revision : 1.0 - initial release
// ============================================================================
module day07_rom_loader #(
    parameter int N_ADDR_BITS = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             in_byte,
    input  logic                   in_valid,
    input  logic                   in_last,
    output logic                   in_ready,
    input  logic [N_ADDR_BITS:0]   rom_addr,
    output logic [7:0]             rom_data,
    output logic                   rom_valid,
    output logic                   core_rst,
    output logic [N_ADDR_BITS:0]   byte_count,
    output logic                   overflow,
    output logic                   load_done
);

    localparam int                   DEPTH   = 2 ** N_ADDR_BITS;
    localparam logic [N_ADDR_BITS:0] C_DEPTH = {1'b1, {N_ADDR_BITS{1'b0}}};
    localparam logic [N_ADDR_BITS:0] C_ONE   = {{N_ADDR_BITS{1'b0}}, 1'b1};
    localparam logic [7:0]           C_CR    = 8'h0D;
    localparam logic [7:0]           C_LF    = 8'h0A;

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_TERM = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   w_in_ready;

    logic [7:0]             r_mem [DEPTH];
    logic [N_ADDR_BITS:0]   r_byte_count;
    logic [7:0]             r_last_byte;
    logic                   r_overflow;
    logic                   r_rom_valid;
    logic                   r_core_rst;
    logic                   r_load_done;

    logic                   w_xfer;
    logic                   w_keep;
    logic                   w_has_room;
    logic                   w_store;
    logic                   w_drop;
    logic                   w_need_nl;
    logic                   w_append;
    logic                   w_nl_ovf;
    logic                   w_rd_hit;
    logic [N_ADDR_BITS-1:0] w_wr_idx;

    // Next-state and handshake decode; only S_LOAD accepts input.
    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        case (r_state)
            S_LOAD: begin
                w_in_ready = 1'b1;
                if (in_valid && in_last) begin
                    w_state_next = S_TERM;
                end
            end
            S_TERM:  w_state_next = S_RUN;
            S_RUN:   w_state_next = S_RUN;
            default: w_state_next = S_LOAD;
        endcase
    end

    // Byte_count never exceeds DEPTH, so "room" is simply count < DEPTH.
    assign w_has_room = (r_byte_count < C_DEPTH);
    assign w_xfer     = in_valid && w_in_ready;
    assign w_keep     = w_xfer && (in_byte != C_CR);
    assign w_store    = w_keep && w_has_room;
    assign w_drop     = w_keep && !w_has_room;
    assign w_need_nl  = (r_state == S_TERM) && (r_byte_count != '0) && (r_last_byte != C_LF);
    assign w_append   = w_need_nl && w_has_room;
    assign w_nl_ovf   = w_need_nl && !w_has_room;
    assign w_wr_idx   = r_byte_count[N_ADDR_BITS-1:0];

    // State register, counters, sticky overflow and core-facing flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_LOAD;
            r_byte_count <= '0;
            r_last_byte  <= 8'h00;
            r_overflow   <= 1'b0;
            r_rom_valid  <= 1'b0;
            r_core_rst   <= 1'b1;
            r_load_done  <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_load_done <= 1'b0;
            if (w_store) begin
                r_byte_count <= r_byte_count + C_ONE;
                r_last_byte  <= in_byte;
            end else if (w_append) begin
                r_byte_count <= r_byte_count + C_ONE;
                r_last_byte  <= C_LF;
            end
            if (w_drop || w_nl_ovf) begin
                r_overflow <= 1'b1;
            end
            if (r_state == S_TERM) begin
                r_rom_valid <= 1'b1;
                r_core_rst  <= 1'b0;
                r_load_done <= 1'b1;
            end
        end
    end

    // Byte RAM write port; contents survive reset and are hidden by byte_count.
    always_ff @(posedge clk) begin
        if (w_store) begin
            r_mem[w_wr_idx] <= in_byte;
        end else if (w_append) begin
            r_mem[w_wr_idx] <= C_LF;
        end
    end

    // Combinational read: the core samples data in the cycle it drives the
    // address. Anything unloaded or out of range reads as 0x00 (EOF marker).
    assign w_rd_hit = (r_state == S_RUN) && (rom_addr < r_byte_count);
    assign rom_data = w_rd_hit ? r_mem[rom_addr[N_ADDR_BITS-1:0]] : 8'h00;

    assign in_ready   = w_in_ready;
    assign rom_valid  = r_rom_valid;
    assign core_rst   = r_core_rst;
    assign byte_count = r_byte_count;
    assign overflow   = r_overflow;
    assign load_done  = r_load_done;

endmodule
`default_nettype wire

// File: tb/tb_day07_rom_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_day07_rom_loader
//  Brief    : Self-checking bench for day07_rom_loader. Two instances (large
//             and 8-byte deep) see the same stream; a queue-based model
//             predicts the stored text for each depth.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_day07_rom_loader;

    localparam int NB = 16;
    localparam int NS = 3;

    typedef logic [7:0] bq_t[$];

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    in_byte = 8'h00;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic [NB:0]   addr_b = '0;
    logic [NS:0]   addr_s = '0;

    logic          ready_b, valid_b, crst_b, ovf_b, done_b;
    logic          ready_s, valid_s, crst_s, ovf_s, done_s;
    logic [7:0]    data_b, data_s;
    logic [NB:0]   cnt_b;
    logic [NS:0]   cnt_s;

    int n_checks = 0;
    int n_pass   = 0;

    // Observations recorded by the stream driver
    int   obs_sent, obs_ready_cycles;
    bit   obs_ready_all, obs_pre_zero;
    logic obs_term_ready, obs_term_done, obs_term_crst;
    logic obs_run_done, obs_run_valid, obs_run_crst, obs_run_ready, obs_after_done;
    bq_t  rd_b, rd_s, rd_m;

    day07_rom_loader #(.N_ADDR_BITS(NB)) u_big (
        .clk(clk), .rst(rst), .in_byte(in_byte), .in_valid(in_valid), .in_last(in_last),
        .in_ready(ready_b), .rom_addr(addr_b), .rom_data(data_b), .rom_valid(valid_b),
        .core_rst(crst_b), .byte_count(cnt_b), .overflow(ovf_b), .load_done(done_b)
    );

    day07_rom_loader #(.N_ADDR_BITS(NS)) u_small (
        .clk(clk), .rst(rst), .in_byte(in_byte), .in_valid(in_valid), .in_last(in_last),
        .in_ready(ready_s), .rom_addr(addr_s), .rom_data(data_s), .rom_valid(valid_s),
        .core_rst(crst_s), .byte_count(cnt_s), .overflow(ovf_s), .load_done(done_s)
    );

    always #5 clk = ~clk;

    // Reference: drop CRs, keep what fits, then append a newline if needed.
    function automatic bq_t model(input bq_t s, input int depth, output bit ovf);
        bq_t m;
        ovf = 1'b0;
        foreach (s[i]) begin
            if (s[i] != 8'h0D) begin
                if (m.size() < depth) m.push_back(s[i]);
                else ovf = 1'b1;
            end
        end
        if (m.size() > 0 && m[m.size()-1] != 8'h0A) begin
            if (m.size() < depth) m.push_back(8'h0A);
            else ovf = 1'b1;
        end
        return m;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    // Streams bytes with random idle cycles; in_last on the final byte if asked.
    task automatic drive_stream(input bq_t s, input int idle_pct, input bit with_last);
        int i = 0;
        int cyc = 0;
        obs_ready_all = 1'b1; obs_pre_zero = 1'b1; obs_ready_cycles = 0;
        addr_b = '0; addr_s = '0;
        while (i < s.size() && cyc < 5000) begin
            @(negedge clk);
            in_valid = (int'($urandom_range(0, 99)) >= idle_pct);
            in_byte  = s[i];
            in_last  = with_last && (i == s.size() - 1);
            #1;
            if (ready_b !== 1'b1 || ready_s !== 1'b1) obs_ready_all = 1'b0;
            else obs_ready_cycles++;
            if (data_b !== 8'h00 || data_s !== 8'h00 || valid_b !== 1'b0 ||
                crst_b !== 1'b1 || crst_s !== 1'b1) obs_pre_zero = 1'b0;
            @(posedge clk);
            if (in_valid) i++;
            cyc++;
        end
        obs_sent = i;
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0; in_byte = 8'h00;
        if (with_last) begin
            #1;
            obs_term_ready = ready_b; obs_term_done = done_b; obs_term_crst = crst_b;
            @(negedge clk); #1;
            obs_run_done  = done_b & done_s;
            obs_run_valid = valid_b & valid_s;
            obs_run_crst  = crst_b | crst_s;
            obs_run_ready = ready_b | ready_s;
            @(negedge clk); #1;
            obs_after_done = done_b | done_s;
        end
    endtask

    // Reads n+4 low addresses on the big instance, all 16 on the small one
    // (MSB-set included), and 4 MSB-set addresses on the big one.
    task automatic read_back(input int n);
        rd_b = {}; rd_s = {}; rd_m = {};
        for (int a = 0; a < n + 4; a++) begin
            addr_b = a[NB:0]; #1; rd_b.push_back(data_b);
        end
        for (int a = 0; a < 16; a++) begin
            addr_s = a[NS:0]; #1; rd_s.push_back(data_s);
        end
        for (int a = 0; a < 4; a++) begin
            addr_b = a[NB:0]; addr_b[NB] = 1'b1; #1; rd_m.push_back(data_b);
        end
        addr_b = '0; addr_s = '0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (ready_b !== 1'b1 || ready_s !== 1'b1) $display("FAIL reset.in_ready got %b/%b want 1/1", ready_b, ready_s); else n_pass++;
        n_checks++; if (cnt_b !== '0 || cnt_s !== '0) $display("FAIL reset.byte_count got %0d/%0d want 0", cnt_b, cnt_s); else n_pass++;
        n_checks++; if (ovf_b !== 1'b0 || ovf_s !== 1'b0) $display("FAIL reset.overflow got %b/%b want 0", ovf_b, ovf_s); else n_pass++;
        n_checks++; if (valid_b !== 1'b0 || crst_b !== 1'b1 || done_b !== 1'b0) $display("FAIL reset.flags got valid=%b crst=%b done=%b want 0 1 0", valid_b, crst_b, done_b); else n_pass++;
        n_checks++; if (data_b !== 8'h00 || data_s !== 8'h00) $display("FAIL reset.rom_data got %h/%h want 00", data_b, data_s); else n_pass++;
    endtask

    task automatic test_back_to_back();
        bq_t s, mb, ms;
        bit ob, os;
        int bad = 0;
        s  = {8'h2E, 8'h53, 8'h2E, 8'h0A, 8'h5E, 8'h2E, 8'h5E, 8'h0A};
        mb = model(s, 1 << NB, ob);
        ms = model(s, 1 << NS, os);
        do_reset();
        drive_stream(s, 0, 1'b1);
        read_back(mb.size());
        n_checks++; if (!obs_ready_all || obs_ready_cycles != 8 || obs_sent != 8) $display("FAIL b2b.in_ready got %0d ready cycles want 8", obs_ready_cycles); else n_pass++;
        n_checks++; if (!obs_pre_zero) $display("FAIL b2b.preload_read got nonzero/ready want rom_data 0 valid 0 crst 1"); else n_pass++;
        n_checks++; if (obs_term_ready !== 1'b0 || obs_term_done !== 1'b0 || obs_term_crst !== 1'b1) $display("FAIL b2b.term got ready=%b done=%b crst=%b want 0 0 1", obs_term_ready, obs_term_done, obs_term_crst); else n_pass++;
        n_checks++; if (obs_run_done !== 1'b1 || obs_run_valid !== 1'b1 || obs_run_crst !== 1'b0 || obs_run_ready !== 1'b0) $display("FAIL b2b.run_entry got done=%b valid=%b crst=%b ready=%b want 1 1 0 0", obs_run_done, obs_run_valid, obs_run_crst, obs_run_ready); else n_pass++;
        n_checks++; if (obs_after_done !== 1'b0) $display("FAIL b2b.load_done_pulse got %b want 0", obs_after_done); else n_pass++;
        n_checks++; if (cnt_b !== 17'(mb.size()) || cnt_s !== 4'(ms.size())) $display("FAIL b2b.byte_count got %0d/%0d want %0d/%0d", cnt_b, cnt_s, mb.size(), ms.size()); else n_pass++;
        n_checks++; if (ovf_b !== ob || ovf_s !== os) $display("FAIL b2b.overflow got %b/%b want %b/%b", ovf_b, ovf_s, ob, os); else n_pass++;
        n_checks++; if (rd_b[1] !== 8'h53 || rd_b[7] !== 8'h0A || rd_b[8] !== 8'h00) $display("FAIL b2b.reads got %h %h %h want 53 0a 00", rd_b[1], rd_b[7], rd_b[8]); else n_pass++;
        foreach (rd_b[a]) if (rd_b[a] !== ((a < mb.size()) ? mb[a] : 8'h00)) bad++;
        foreach (rd_s[a]) if (rd_s[a] !== ((a < ms.size()) ? ms[a] : 8'h00)) bad++;
        foreach (rd_m[a]) if (rd_m[a] !== 8'h00) bad++;
        n_checks++; if (bad != 0) $display("FAIL b2b.contents got %0d wrong bytes want 0", bad); else n_pass++;
    endtask

    task automatic test_crlf();
        bq_t s, mb, ms;
        bit ob, os;
        int bad = 0;
        do_reset();
        n_checks++; if (crst_b !== 1'b1 || valid_b !== 1'b0 || cnt_b !== '0 || ready_b !== 1'b1) $display("FAIL run_reset.flags got crst=%b valid=%b cnt=%0d ready=%b want 1 0 0 1", crst_b, valid_b, cnt_b, ready_b); else n_pass++;
        s  = {8'h61, 8'h62, 8'h0D, 8'h0A, 8'h63, 8'h64};
        mb = model(s, 1 << NB, ob);
        ms = model(s, 1 << NS, os);
        drive_stream(s, 0, 1'b1);
        read_back(mb.size());
        n_checks++; if (cnt_b !== 17'd6 || cnt_s !== 4'(ms.size())) $display("FAIL crlf.byte_count got %0d/%0d want 6/%0d", cnt_b, cnt_s, ms.size()); else n_pass++;
        n_checks++; if (rd_b[2] !== 8'h0A || rd_b[5] !== 8'h0A || rd_b[6] !== 8'h00) $display("FAIL crlf.reads got %h %h %h want 0a 0a 00", rd_b[2], rd_b[5], rd_b[6]); else n_pass++;
        foreach (rd_b[a]) if (rd_b[a] !== ((a < mb.size()) ? mb[a] : 8'h00)) bad++;
        foreach (rd_s[a]) if (rd_s[a] !== ((a < ms.size()) ? ms[a] : 8'h00)) bad++;
        n_checks++; if (bad != 0) $display("FAIL crlf.contents got %0d wrong bytes want 0", bad); else n_pass++;
    endtask

    task automatic test_gaps();
        bq_t s, mb, ms;
        bit ob, os;
        int bad;
        logic [7:0] pool [6] = '{8'h2E, 8'h5E, 8'h53, 8'h0D, 8'h0A, 8'h7C};
        for (int rep = 0; rep < 3; rep++) begin
            s = {};
            bad = 0;
            for (int i = 0; i < 20 + rep * 7; i++) s.push_back(pool[$urandom_range(0, 5)]);
            mb = model(s, 1 << NB, ob);
            ms = model(s, 1 << NS, os);
            do_reset();
            drive_stream(s, 30, 1'b1);
            read_back(mb.size());
            n_checks++; if (!obs_ready_all || obs_sent != s.size() || obs_run_done !== 1'b1) $display("FAIL gaps.handshake got sent=%0d done=%b want %0d 1", obs_sent, obs_run_done, s.size()); else n_pass++;
            n_checks++; if (cnt_b !== 17'(mb.size()) || cnt_s !== 4'(ms.size()) || ovf_b !== ob || ovf_s !== os) $display("FAIL gaps.count got %0d/%0d ovf %b/%b want %0d/%0d ovf %b/%b", cnt_b, cnt_s, ovf_b, ovf_s, mb.size(), ms.size(), ob, os); else n_pass++;
            foreach (rd_b[a]) if (rd_b[a] !== ((a < mb.size()) ? mb[a] : 8'h00)) bad++;
            foreach (rd_s[a]) if (rd_s[a] !== ((a < ms.size()) ? ms[a] : 8'h00)) bad++;
            foreach (rd_m[a]) if (rd_m[a] !== 8'h00) bad++;
            n_checks++; if (bad != 0) $display("FAIL gaps.contents got %0d wrong bytes want 0", bad); else n_pass++;
        end
    endtask

    task automatic test_overflow();
        bq_t s, mb, ms;
        bit ob, os;
        int bad = 0;
        for (int i = 0; i < 10; i++) s.push_back(8'(8'h61 + $urandom_range(0, 25)));
        mb = model(s, 1 << NB, ob);
        ms = model(s, 1 << NS, os);
        do_reset();
        drive_stream(s, 10, 1'b1);
        read_back(mb.size());
        n_checks++; if (cnt_s !== 4'd8 || ovf_s !== 1'b1) $display("FAIL ovf.small got cnt=%0d ovf=%b want 8 1", cnt_s, ovf_s); else n_pass++;
        n_checks++; if (valid_s !== 1'b1 || crst_s !== 1'b0) $display("FAIL ovf.small_run got valid=%b crst=%b want 1 0", valid_s, crst_s); else n_pass++;
        n_checks++; if (cnt_b !== 17'd11 || ovf_b !== 1'b0) $display("FAIL ovf.big got cnt=%0d ovf=%b want 11 0", cnt_b, ovf_b); else n_pass++;
        foreach (rd_b[a]) if (rd_b[a] !== ((a < mb.size()) ? mb[a] : 8'h00)) bad++;
        foreach (rd_s[a]) if (rd_s[a] !== ((a < ms.size()) ? ms[a] : 8'h00)) bad++;
        n_checks++; if (bad != 0) $display("FAIL ovf.contents got %0d wrong bytes want 0", bad); else n_pass++;
    endtask

    task automatic test_reset_mid_load();
        bq_t s1, s2, mb;
        bit ob;
        int bad = 0;
        s1 = {8'h61, 8'h62, 8'h63};
        s2 = {8'h78, 8'h0A};
        mb = model(s2, 1 << NB, ob);
        do_reset();
        drive_stream(s1, 0, 1'b0);
        do_reset();
        n_checks++; if (cnt_b !== '0 || crst_b !== 1'b1 || ready_b !== 1'b1) $display("FAIL midrst.state got cnt=%0d crst=%b ready=%b want 0 1 1", cnt_b, crst_b, ready_b); else n_pass++;
        drive_stream(s2, 0, 1'b1);
        read_back(mb.size());
        n_checks++; if (!obs_pre_zero || obs_term_crst !== 1'b1 || obs_run_crst !== 1'b0) $display("FAIL midrst.core_rst got pre=%b term=%b run=%b want 1 1 0", obs_pre_zero, obs_term_crst, obs_run_crst); else n_pass++;
        n_checks++; if (cnt_b !== 17'd2 || cnt_s !== 4'd2) $display("FAIL midrst.byte_count got %0d/%0d want 2/2", cnt_b, cnt_s); else n_pass++;
        n_checks++; if (rd_b[2] !== 8'h00 || rd_s[2] !== 8'h00) $display("FAIL midrst.stale got %h/%h want 00", rd_b[2], rd_s[2]); else n_pass++;
        foreach (rd_b[a]) if (rd_b[a] !== ((a < mb.size()) ? mb[a] : 8'h00)) bad++;
        n_checks++; if (bad != 0) $display("FAIL midrst.contents got %0d wrong bytes want 0", bad); else n_pass++;
    endtask

    task automatic test_empty();
        bq_t s;
        int bad = 0;
        s = {8'h0D};
        do_reset();
        drive_stream(s, 0, 1'b1);
        read_back(0);
        n_checks++; if (cnt_b !== '0 || cnt_s !== '0 || ovf_b !== 1'b0) $display("FAIL empty.byte_count got %0d/%0d ovf=%b want 0 0 0", cnt_b, cnt_s, ovf_b); else n_pass++;
        n_checks++; if (obs_run_done !== 1'b1 || valid_b !== 1'b1) $display("FAIL empty.run got done=%b valid=%b want 1 1", obs_run_done, valid_b); else n_pass++;
        foreach (rd_b[a]) if (rd_b[a] !== 8'h00) bad++;
        foreach (rd_s[a]) if (rd_s[a] !== 8'h00) bad++;
        n_checks++; if (bad != 0) $display("FAIL empty.contents got %0d nonzero bytes want 0", bad); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_crlf();
        test_gaps();
        test_overflow();
        test_reset_mid_load();
        test_empty();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
